// File: rtl/digit_scan_ctrl_pkg.sv
// disp_pkg: scan FSM state type and digit-enable helper shared by the display scan logic.
package disp_pkg;
  typedef enum logic [1:0] {IDLE, ON, GAP} scan_state_t;
  localparam int NUM_DIGITS = 4;
  function automatic logic [3:0] onehot_low(logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction
endpackage

// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: enable/mask inputs and mux-select/digit-enable outputs of the scan controller.
interface digit_scan_ctrl_if;
  logic       en;
  logic [3:0] blank_mask;
  logic [1:0] sel2;
  logic [3:0] an;
  logic       digit_tick;
  modport master (output en, blank_mask, input sel2, an, digit_tick);
  modport slave (input en, blank_mask, output sel2, an, digit_tick);
endinterface

// File: rtl/digit_scan_ctrl_timer.sv
// scan_timer: loadable down-counter with clear; done while the count sits at zero.
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done_o = cnt_q == '0;
  always_comb cnt_d = clr_i ? '0 : load_i ? load_val_i : done_o ? cnt_q : cnt_q - W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: steps a 4-digit display mux select with per-digit ON slots and blanking gaps.
module digit_scan_ctrl import disp_pkg::*; #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000
) (
  input logic              clk,
  input logic              rst,
  digit_scan_ctrl_if.slave dsp
);
  localparam int MAXC = DIV > BLANK_CYC ? DIV : BLANK_CYC;
  localparam int W = $clog2(MAXC > 2 ? MAXC : 2);
  localparam logic [W-1:0] ON_LD = W'(DIV - 1);
  localparam logic [W-1:0] GAP_LD = W'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
  scan_state_t state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [3:0]   an_q, an_d;
  logic         tick_q, tick_d;
  logic         done, adv, load, clr;
  logic [W-1:0] load_val;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      an_q    <= 4'hF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  // the unused fourth code falls through to the IDLE branch
  always_comb begin
    adv     = dsp.en && state_q == ON && done;
    state_d = !dsp.en ? IDLE :
              state_q == ON  ? (done && BLANK_CYC > 0 ? GAP : ON) :
              state_q == GAP ? (done ? ON : GAP) : ON;
  end
  // an is derived from the next sel so enable and mux data switch on the same edge
  always_comb begin
    sel_d    = adv ? sel_q + 2'd1 : sel_q;
    tick_d   = adv;
    an_d     = state_d == ON && !dsp.blank_mask[sel_d] ? onehot_low(sel_d) : 4'hF;
    clr      = state_d == IDLE;
    load     = (state_d == ON && (state_q != ON || adv)) || (state_d == GAP && state_q != GAP);
    load_val = state_d == GAP ? GAP_LD : ON_LD;
  end
  scan_timer #(.W(W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .load_i    (load),
    .load_val_i(load_val),
    .done_o    (done)
  );
  assign dsp.sel2       = sel_q;
  assign dsp.an         = an_q;
  assign dsp.digit_tick = tick_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: random and directed scan stimulus checked against a slot-arithmetic model.
module tb_digit_scan_ctrl;
  localparam int DIV = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_r = 1'b0;
  logic [3:0] mask_r = 4'h0;
  int checks = 0;
  int errors = 0;
  int         m_sel [2];
  int         m_t   [2];
  bit         m_idle[2];
  logic [3:0] m_an  [2];
  bit         m_tick[2];
  digit_scan_ctrl_if if_a ();
  digit_scan_ctrl_if if_b ();
  assign if_a.en = en_r;
  assign if_a.blank_mask = mask_r;
  assign if_b.en = en_r;
  assign if_b.blank_mask = mask_r;
  digit_scan_ctrl #(.DIV(DIV), .BLANK_CYC(2)) u_a (.clk(clk), .rst(rst), .dsp(if_a));
  digit_scan_ctrl #(.DIV(DIV), .BLANK_CYC(0)) u_b (.clk(clk), .rst(rst), .dsp(if_b));
  always #5 clk = ~clk;
  function automatic int blk(input int k);
    return k == 0 ? 2 : 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // model: a digit period is DIV lit cycles then blk(k) dark cycles, position t within it
  task automatic step(input int k);
    m_tick[k] = 0;
    if (!en_r) m_idle[k] = 1;
    else if (m_idle[k]) begin
      m_idle[k] = 0;
      m_t[k] = 0;
    end else begin
      if (m_t[k] == DIV - 1) begin
        m_sel[k] = (m_sel[k] + 1) % 4;
        m_tick[k] = 1;
      end
      m_t[k] = (m_t[k] + 1) % (DIV + blk(k));
    end
    m_an[k] = (!m_idle[k] && m_t[k] < DIV && !mask_r[m_sel[k]]) ? ~(4'b0001 << m_sel[k]) : 4'hF;
  endtask
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        m_sel[k] = 0;
        m_t[k] = 0;
        m_idle[k] = 1;
        m_an[k] = 4'hF;
        m_tick[k] = 0;
      end else step(k);
  always @(negedge clk) begin
    chk("a_sel2", if_a.sel2, m_sel[0]);
    chk("a_an", if_a.an, m_an[0]);
    chk("a_tick", if_a.digit_tick, m_tick[0]);
    chk("b_sel2", if_b.sel2, m_sel[1]);
    chk("b_an", if_b.an, m_an[1]);
    chk("b_tick", if_b.digit_tick, m_tick[1]);
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_sel2", if_a.sel2, 0);
    chk("rst_an", if_a.an, 4'hF);
    chk("rst_tick", if_a.digit_tick, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_an", if_a.an, 4'hF);
    en_r = 1'b1;
    repeat (60) @(negedge clk);
    mask_r = 4'b0100;
    repeat (48) @(negedge clk);
    mask_r = 4'h0;
    n = 0;
    while (!(m_sel[0] == 1 && m_t[0] == 2 && !m_idle[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pause_wait", n < 100, 1);
    en_r = 1'b0;
    @(negedge clk);
    chk("pause_an", if_a.an, 4'hF);
    chk("pause_sel2", if_a.sel2, 1);
    chk("pause_tick", if_a.digit_tick, 0);
    repeat (4) @(negedge clk);
    en_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("resume_an", if_a.an, 4'b1101);
    end
    n = 0;
    while (!(m_tick[0] && m_sel[0] == 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("gap_wait", n < 100, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel2", if_a.sel2, 0);
    chk("arst_an", if_a.an, 4'hF);
    chk("arst_b_an", if_b.an, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_an", if_a.an, 4'b1110);
    chk("restart_sel2", if_a.sel2, 0);
    repeat (3000) begin
      @(negedge clk);
      en_r = $urandom_range(0, 19) != 0;
      if ($urandom_range(0, 15) == 0) mask_r = 4'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
